data_ram_responder: RTL
=======================

Name: data_ram_responder

Overview:
Responder end of the data-RAM interface driven by the execute stage. It accepts en/addr/byte-write-enable/write-data requests and commits byte-masked writes. It returns full 32-bit read words after a fixed, parameterised latency. It runs a post-reset clear sequence and flags out-of-range addresses. It sits in the SoC/testbench memory subsystem and feeds read data to the memory-access stage.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >=4
BASE_ADDR, 32'h0000_0000, byte base address; aligned to DEPTH*4
READ_LAT, 1, read latency in cycles; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
data_ram_en  in  1  request valid this cycle
data_ram_addr  in  32  byte address; bits [1:0] ignored for word select
data_ram_w_en  in  4  byte write enables; 4'b0000 with en=1 means read
data_ram_w_data  in  32  write data, byte lanes aligned to w_en
data_ram_r_data  out  32  read word
data_ram_r_valid  out  1  one-cycle pulse, r_data valid
data_ram_addr_err  out  1  one-cycle pulse, request addressed outside the window
init_done  out  1  high once the clear sequence has finished and requests are accepted

Behaviour:
- Reset: async assert clears r_data=0, r_valid=0, addr_err=0, and all latency-pipe valid bits. FSM goes to CLEAR if CLEAR_ON_RESET=1, else to READY. init_done=0 while in CLEAR.
- Array contents are not reset-clocked. With CLEAR_ON_RESET=0 they survive reset.
- Address decode: idx = addr[log2(DEPTH)+1:2]. in_range = (addr[31:log2(DEPTH)+2] == BASE_ADDR[31:log2(DEPTH)+2]).
- FSM CLEAR:
  - A clear counter runs 0..DEPTH-1 and writes 0 to word[counter] each cycle.
  - After the cycle writing DEPTH-1, the FSM moves to READY. init_done rises the following cycle and stays high.
  - Total: init_done goes high DEPTH+1 cycles after reset deassertion.
  - Requests in CLEAR are dropped silently: no write, no r_valid, no addr_err.
- FSM READY: accepts one request per cycle; no back-pressure.
- Write (en=1, w_en!=0, in_range):
  - At the posedge, byte i of word[idx] is replaced by w_data[8i+7:8i] wherever w_en[i]=1.
  - Other bytes are unchanged.
  - No r_valid pulse is produced.
- Read (en=1, w_en=0, in_range):
  - The word is sampled at the accepting posedge and carried through a READ_LAT-deep valid/data pipe.
  - r_valid=1 and r_data=word in exactly cycle N+READ_LAT, where N is the request cycle.
- Read-after-write: a read in cycle N+1 of an address written in cycle N returns the new data. No forwarding is needed because the write commits at the end of cycle N.
- Back-to-back reads: one result per cycle, in request order, with no bubbles.
- Out of range (en=1, !in_range):
  - No array access.
  - addr_err pulses in cycle N+READ_LAT; r_valid stays 0 that cycle.
  - Applies to both reads and writes.
- r_valid and addr_err are never both 1 in the same cycle.
- r_data holds its last valid value while r_valid=0.
- en=0: no effect; w_en, addr and w_data are don't-care.
- Reset mid-operation:
  - In-flight reads are discarded; no r_valid after reset.
  - A partially completed CLEAR restarts from 0.
  - A write on the same edge as reset assertion is not guaranteed to commit.
- Illegal READ_LAT outside 1..4 is an elaboration error.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (CLEAR, READY)
  - the data-RAM request/response bus widths, added beside the existing inter-stage bus width constants
  - READ_LAT legal bounds
- One natural sub-module: data_ram_lat_pipe, the parameterised READ_LAT-stage pipe of {valid, err, data[31:0]} with async reset on the valid/err bits.

Test Plan:
- Clear: reset with DEPTH=16, CLEAR_ON_RESET=1 -> init_done rises 17 cycles after reset falls. A read of every word then returns 32'h0. A read issued at cycle 3 of CLEAR produces no r_valid.
- Byte write: write 32'hAABBCCDD with w_en=4'b1111 to addr 0x8, then w_data=32'h11223344 with w_en=4'b0100 -> a read of 0x8 returns 32'hAA22CCDD.
- Latency: READ_LAT=3, reads issued at cycles 10, 11, 12 to three distinct words -> r_valid high at cycles 13, 14, 15 with matching data and no gaps.
- Read-after-write: write 32'hDEADBEEF to 0x4 in cycle N and read 0x4 in cycle N+1 -> with READ_LAT=1, r_data=32'hDEADBEEF in N+2.
- Range: DEPTH=16, BASE_ADDR=0, read of 0x40 -> addr_err pulses after READ_LAT with r_valid=0. A write of 0x40 leaves word 0 unchanged.
- Reset mid-flight: READ_LAT=4, read issued, reset asserted two cycles later -> r_valid never pulses and all outputs read 0 while reset is high.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data-RAM responder: bus widths, FSM encoding and latency bounds.
package data_ram_responder_pkg;

   // Inter-stage bus widths
   localparam int unsigned XLEN        = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned PC_W        = 32;

   // Data-RAM request/response bus widths
   localparam int unsigned DRAM_ADDR_W = 32;
   localparam int unsigned DRAM_DATA_W = 32;
   localparam int unsigned DRAM_BE_W   = DRAM_DATA_W / 8;

   localparam int unsigned READ_LAT_MIN = 1;
   localparam int unsigned READ_LAT_MAX = 4;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } dram_state_e;

   // Replace the byte lanes of old_w selected by be with the matching lanes of new_w.
   function automatic logic [DRAM_DATA_W-1:0] byte_merge(
      input logic [DRAM_DATA_W-1:0] old_w,
      input logic [DRAM_DATA_W-1:0] new_w,
      input logic [DRAM_BE_W-1:0]   be
   );
      logic [DRAM_DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(DRAM_BE_W); i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/data_ram_lat_pipe.sv
// READ_LAT-deep pipe carrying {valid, err, data}; data registers load only behind a valid
// so the last stage holds the most recent read word while no result is presented.
module data_ram_lat_pipe
   import data_ram_responder_pkg::*;
#(
   parameter int unsigned LAT = 1,
   parameter int unsigned W   = DRAM_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_valid,
   input  logic         i_err,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic         o_err,
   output logic [W-1:0] o_data
);

   logic [LAT-1:0] r_valid;
   logic [LAT-1:0] r_err;
   logic [W-1:0]   r_data [LAT];

   // Shift valid/err every cycle; advance data only alongside a valid read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_err   <= '0;
         for (int i = 0; i < int'(LAT); i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         r_err[0]   <= i_err;
         if (i_valid) begin
            r_data[0] <= i_data;
         end
         for (int i = 1; i < int'(LAT); i++) begin
            r_valid[i] <= r_valid[i-1];
            r_err[i]   <= r_err[i-1];
            if (r_valid[i-1]) begin
               r_data[i] <= r_data[i-1];
            end
         end
      end
   end

   assign o_valid = r_valid[LAT-1];
   assign o_err   = r_err[LAT-1];
   assign o_data  = r_data[LAT-1];

endmodule

// File: rtl/data_ram_responder.sv
// Data-RAM responder: byte-masked writes, fixed-latency reads, post-reset clear and
// out-of-window address flagging.
module data_ram_responder
   import data_ram_responder_pkg::*;
#(
   parameter int unsigned DEPTH          = 1024,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned READ_LAT       = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_ram_en,
   input  logic [DRAM_ADDR_W-1:0] data_ram_addr,
   input  logic [DRAM_BE_W-1:0]   data_ram_w_en,
   input  logic [DRAM_DATA_W-1:0] data_ram_w_data,
   output logic [DRAM_DATA_W-1:0] data_ram_r_data,
   output logic                   data_ram_r_valid,
   output logic                   data_ram_addr_err,
   output logic                   init_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam dram_state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

   if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
      $error("data_ram_responder: READ_LAT must lie in 1..4");
   end
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("data_ram_responder: DEPTH must be a power of two >= 4");
   end

   logic [DRAM_DATA_W-1:0] r_mem [DEPTH];
   dram_state_e            r_state;
   dram_state_e            w_state_nxt;
   logic [IDX_W-1:0]       r_clr_cnt;
   logic [IDX_W-1:0]       w_clr_cnt_nxt;
   logic                   r_init_done;

   logic [IDX_W-1:0]       w_idx;
   logic                   w_in_range;
   logic                   w_accept;
   logic                   w_wr;
   logic                   w_rd;
   logic                   w_err;
   logic [DRAM_DATA_W-1:0] w_rd_word;
   logic                   w_unused_addr_lsb;

   assign w_idx             = data_ram_addr[IDX_W+1:2];
   assign w_in_range        = (data_ram_addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
   assign w_unused_addr_lsb = ^data_ram_addr[1:0];

   assign w_accept  = (r_state == ST_READY) && data_ram_en;
   assign w_wr      = w_accept && w_in_range && (data_ram_w_en != 4'b0000);
   assign w_rd      = w_accept && w_in_range && (data_ram_w_en == 4'b0000);
   assign w_err     = w_accept && !w_in_range;
   assign w_rd_word = r_mem[w_idx];

   // Next-state logic: sweep the clear counter once, then stay in READY.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
               w_state_nxt   = ST_READY;
               w_clr_cnt_nxt = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
            end
         end
         ST_READY: begin
            w_state_nxt = ST_READY;
         end
         default: begin
            w_state_nxt   = ST_CLEAR;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   // State, clear counter and init_done; init_done trails READY by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RST_STATE;
         r_clr_cnt   <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_clr_cnt   <= w_clr_cnt_nxt;
         r_init_done <= (r_state == ST_READY);
      end
   end

   // Storage is not reset; it is either swept to zero by CLEAR or written by requests.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
         end else if (w_wr) begin
            r_mem[w_idx] <= byte_merge(r_mem[w_idx], data_ram_w_data, data_ram_w_en);
         end
      end
   end

   data_ram_lat_pipe #(
      .LAT (READ_LAT),
      .W   (DRAM_DATA_W)
   ) u_lat_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_rd),
      .i_err   (w_err),
      .i_data  (w_rd_word),
      .o_valid (data_ram_r_valid),
      .o_err   (data_ram_addr_err),
      .o_data  (data_ram_r_data)
   );

   assign init_done = r_init_done;

endmodule
